// File: rtl/seq_ser_pkg.sv
// Shared types and defaults for the MSB-first word serializer.
package seq_ser_pkg;

  localparam int SEQ_SER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial converter with a 1-entry hold register for gapless frames.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after each word.
//
// state | meaning
// IDLE  | no frame in flight, line quiet, ready for a word
// SHIFT | a frame bit is on the line; cnt_q counts bits left including it
module seq_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = SEQ_SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             data,
  output logic             data_valid,
  output logic             frame_start
);

`ifdef SEQ_SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  function automatic logic [FRAME_LEN-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SEQ_SER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fs_q, fs_d;

  logic                 accept;
  logic                 load_en;
  logic [WIDTH-1:0]     load_word;
  logic [FRAME_LEN-1:0] load_frame;

  assign din_ready   = (state_q == IDLE) || !hold_full_q;
  assign accept      = din_valid && din_ready;
  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_start = fs_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    data_d      = 1'b0;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    load_en     = 1'b0;
    load_word   = din;

    case (state_q)
      IDLE: begin
        if (accept) load_en = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          // hold_full blocks din_ready, so the held word and a new accept never collide here
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          data_d  = sreg_q[FRAME_LEN-1];
          valid_d = 1'b1;
          sreg_d  = sreg_q << 1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    load_frame = frame_of(load_word);
    if (load_en) begin
      // first bit goes straight to the output register; the rest wait in sreg
      data_d  = load_frame[FRAME_LEN-1];
      sreg_d  = load_frame << 1;
      valid_d = 1'b1;
      fs_d    = 1'b1;
      cnt_d   = CNT_W'(FRAME_LEN);
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, single word, back-to-back, stall, abort, parity.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic [7:0] din;
  logic       din_ready;
  logic       data;
  logic       data_valid;
  logic       frame_start;

  int vectors = 0;
  int miscompares = 0;

`ifdef SEQ_SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  seq_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .data       (data),
    .data_valid (data_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected frame, left-aligned in 9 bits: word MSB first, then parity if enabled.
  function automatic logic [8:0] fr(input logic [7:0] w);
`ifdef SEQ_SER_PARITY_EN
    return {w, ^w};
`else
    return {w, 1'b0};
`endif
  endfunction

  function automatic logic bit_of(input logic [8:0] f, input int i);
    return f[8-i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    din = 8'h00;
    repeat (3) begin
      step();
      vectors++;
      if (data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold_valid: got %b expected 0", data_valid);
      end
    end
    rst = 1'b0;
    vectors++;
    if (data !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %b expected 0", data);
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", data_valid);
    end
    vectors++;
    if (frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fs: got %b expected 0", frame_start);
    end
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", din_ready);
    end
  endtask

  task automatic test_single();
    logic [8:0] f;
    int starts;
    f = fr(8'b1011_1000);
    starts = 0;
    din = 8'b1011_1000;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = 8'h5F;
    for (int i = 0; i < FL; i++) begin
      vectors++;
      if (data !== bit_of(f, i) || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bit%0d: got data=%b valid=%b expected data=%b valid=1",
                 i, data, data_valid, bit_of(f, i));
      end
      vectors++;
      if (frame_start !== (i == 0)) begin
        miscompares++;
        $display("FAIL single_fs%0d: got %b expected %b", i, frame_start, (i == 0));
      end
      if (frame_start === 1'b1) starts++;
      step();
    end
    vectors++;
    if (data_valid !== 1'b0 || data !== 1'b0 || din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle: got valid=%b data=%b ready=%b expected 0 0 1",
               data_valid, data, din_ready);
    end
    vectors++;
    if (starts != 1) begin
      miscompares++;
      $display("FAIL single_starts: got %0d expected 1", starts);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] fa, fb;
    logic       exp;
    fa = fr(8'hA5);
    fb = fr(8'h3C);
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 2 * FL; i++) begin
      exp = (i < FL) ? bit_of(fa, i) : bit_of(fb, i - FL);
      vectors++;
      if (data !== exp || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got data=%b valid=%b expected data=%b valid=1",
                 i, data, data_valid, exp);
      end
      vectors++;
      if (frame_start !== (i == 0 || i == FL)) begin
        miscompares++;
        $display("FAIL b2b_fs%0d: got %b expected %b", i, frame_start, (i == 0 || i == FL));
      end
      if (i == 0) din = 8'h3C;
      if (i == 1) begin
        vectors++;
        if (din_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready_full: got %b expected 0", din_ready);
        end
        din_valid = 1'b0;
        din = 8'h00;
      end
      if (i == FL) begin
        vectors++;
        if (din_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_drained: got %b expected 1", din_ready);
        end
      end
      step();
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got valid=%b expected 0", data_valid);
    end
  endtask

  task automatic test_stall();
    logic [8:0] f0, f1, f2;
    logic       exp;
    f0 = fr(8'h5A);
    f1 = fr(8'hC3);
    f2 = fr(8'h99);
    din = 8'h5A;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 3 * FL; i++) begin
      if (i < FL) exp = bit_of(f0, i);
      else if (i < 2 * FL) exp = bit_of(f1, i - FL);
      else exp = bit_of(f2, i - 2 * FL);
      vectors++;
      if (data !== exp || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_bit%0d: got data=%b valid=%b expected data=%b valid=1",
                 i, data, data_valid, exp);
      end
      vectors++;
      if (frame_start !== (i == 0 || i == FL || i == 2 * FL)) begin
        miscompares++;
        $display("FAIL stall_fs%0d: got %b expected %b", i, frame_start,
                 (i == 0 || i == FL || i == 2 * FL));
      end
      if (i == 0) din = 8'hC3;
      if (i == 1) din = 8'h99;
      if (i >= 1 && i < FL) begin
        vectors++;
        if (din_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ready%0d: got %b expected 0", i, din_ready);
        end
      end
      if (i == FL) begin
        vectors++;
        if (din_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_ready_open: got %b expected 1", din_ready);
        end
      end
      if (i == FL + 1) begin
        din_valid = 1'b0;
        din = 8'hFF;
      end
      step();
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: got valid=%b expected 0 (duplicate word?)", data_valid);
    end
  endtask

  task automatic test_abort();
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (data !== 1'b1 || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_bit%0d: got data=%b valid=%b expected 1 1", i, data, data_valid);
      end
      if (i == 0) din = 8'h81;
      if (i == 1) begin
        din_valid = 1'b0;
        din = 8'h00;
      end
      if (i < 2) step();
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (data_valid !== 1'b0 || data !== 1'b0 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: got valid=%b data=%b fs=%b expected 0 0 0",
               data_valid, data, frame_start);
    end
    repeat (2) begin
      step();
      vectors++;
      if (data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_hold: got valid=%b expected 0", data_valid);
      end
    end
    rst = 1'b0;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready: got %b expected 1", din_ready);
    end
    for (int i = 0; i < 2 * FL; i++) begin
      step();
      vectors++;
      if (data_valid !== 1'b0 || data !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet%0d: got valid=%b data=%b expected 0 0", i, data_valid, data);
      end
    end
  endtask

`ifdef SEQ_SER_PARITY_EN
  task automatic test_parity();
    logic [8:0] exp_a, exp_b;
    exp_a = 9'b0_0000_1111;
    exp_b = 9'b0_0000_0110;
    din = 8'h07;
    din_valid = 1'b1;
    step();
    din = 8'h03;
    for (int i = 0; i < 2 * FL; i++) begin
      vectors++;
      if (data !== ((i < FL) ? exp_a[8-i] : exp_b[8-(i-FL)]) || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_bit%0d: got data=%b valid=%b expected data=%b valid=1", i,
                 data, data_valid, ((i < FL) ? exp_a[8-i] : exp_b[8-(i-FL)]));
      end
      if (i == 0) begin
        din_valid = 1'b0;
      end
      step();
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_end: got valid=%b expected 0", data_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_abort();
`ifdef SEQ_SER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
